// File: rtl/bldc_pkg.sv
// Encodings shared between the BLDC ESC and its encoder plant model:
// quadrature Gray table, direction codes and speed saturation limits.
package bldc_pkg;

    localparam logic [1:0] DIR_FWD = 2'b10;
    localparam logic [1:0] DIR_REV = 2'b01;

    // Slot q holds the {a,b} code for quadrant q: 00, 01, 11, 10.
    localparam logic [7:0] QUAD_FWD = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic int sat_max(input int data_width);
        return (1 << (data_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int data_width);
        return -sat_max(data_width);
    endfunction

endpackage

// File: rtl/quad_nco.sv
// Phase accumulator driven by model speed; top two phase bits are Gray-coded
// onto the quadrature outputs and quadrant steps are counted into a position.
module quad_nco
    import bldc_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] step,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic [DATA_WIDTH-1:0] position
);

    localparam int PW = DATA_WIDTH + 2;

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic [1:0]    q_old;
    logic [1:0]    q_new;
    logic [1:0]    code;
    logic [1:0]    dir;

    // |step| is below one quadrant, so the quadrant moves by at most one per tick.
    always_comb begin
        phase_next = phase + {{2{step[DATA_WIDTH-1]}}, step};
        q_old      = phase[PW-1 -: 2];
        q_new      = phase_next[PW-1 -: 2];
        code       = QUAD_FWD[{q_new, 1'b0} +: 2];
        dir        = 2'b00;
        if (q_new == q_old + 2'd1) begin
            dir = DIR_FWD;
        end else if (q_new == q_old - 2'd1) begin
            dir = DIR_REV;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            encoder_a <= 1'b0;
            encoder_b <= 1'b0;
            position  <= '0;
        end else if (tick && enable) begin
            phase     <= phase_next;
            encoder_a <= code[1];
            encoder_b <= code[0];
            case (dir)
                DIR_FWD: position <= position + DATA_WIDTH'(1);
                DIR_REV: position <= position - DATA_WIDTH'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bldc_encoder_emulator.sv
// Motor plant model: measures PWM drive duty per window, runs a first-order
// speed model with gain and friction, and emits quadrature encoder signals.
module bldc_encoder_emulator
    import bldc_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int WINDOW_LOG2 = 8,
    parameter int LAG_SHIFT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_en,
    input  logic                  enable,
    input  logic                  motor_positive,
    input  logic                  motor_negative,
    input  logic [7:0]            gain,
    input  logic [7:0]            friction,
    output logic                  encoder_a,
    output logic                  encoder_b,
    output logic [DATA_WIDTH-1:0] speed_o,
    output logic [DATA_WIDTH-1:0] position_o,
    output logic                  window_done,
    output logic                  fault
);

    localparam int CW = WINDOW_LOG2 + 1;
    localparam int EW = DATA_WIDTH + WINDOW_LOG2 + 10;
    localparam logic signed [EW-1:0] SAT_HI = EW'(sat_max(DATA_WIDTH));
    localparam logic signed [EW-1:0] SAT_LO = EW'(sat_min(DATA_WIDTH));

    logic [WINDOW_LOG2-1:0]       win_ctr;
    logic [CW-1:0]                pos_cnt;
    logic [CW-1:0]                neg_cnt;
    logic signed [DATA_WIDTH-1:0] speed;

    logic                         active;
    logic                         drive_fwd;
    logic                         drive_rev;
    logic                         shoot;
    logic                         win_last;
    logic [CW-1:0]                pos_next;
    logic [CW-1:0]                neg_next;
    logic signed [EW-1:0]         drive;
    logic signed [EW-1:0]         target;
    logic signed [EW-1:0]         s_ext;
    logic signed [EW-1:0]         s1;
    logic signed [EW-1:0]         fric;
    logic signed [EW-1:0]         s2;
    logic signed [DATA_WIDTH-1:0] speed_next;

    always_comb begin
        active    = tick_en & enable;
        drive_fwd = motor_positive & ~motor_negative;
        drive_rev = motor_negative & ~motor_positive;
        shoot     = motor_positive & motor_negative;
        win_last  = (win_ctr == '1);
        // The closing tick's own sample belongs to the window being evaluated.
        pos_next  = pos_cnt + CW'(drive_fwd);
        neg_next  = neg_cnt + CW'(drive_rev);
        drive     = $signed(EW'(pos_next)) - $signed(EW'(neg_next));
        target    = drive * $signed(EW'(gain));
        s_ext     = EW'(speed);
        s1        = s_ext + ((target - s_ext) >>> LAG_SHIFT);
        fric      = $signed(EW'(friction));
        if (s1 > fric) begin
            s2 = s1 - fric;
        end else if (s1 < -fric) begin
            s2 = s1 + fric;
        end else begin
            s2 = '0;
        end
        if (s2 > SAT_HI) begin
            speed_next = SAT_HI[DATA_WIDTH-1:0];
        end else if (s2 < SAT_LO) begin
            speed_next = SAT_LO[DATA_WIDTH-1:0];
        end else begin
            speed_next = s2[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_ctr     <= '0;
            pos_cnt     <= '0;
            neg_cnt     <= '0;
            speed       <= '0;
            window_done <= 1'b0;
            fault       <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (tick_en && !enable) begin
                win_ctr <= '0;
                pos_cnt <= '0;
                neg_cnt <= '0;
                speed   <= '0;
            end else if (active) begin
                if (shoot) begin
                    fault <= 1'b1;
                end
                win_ctr <= win_ctr + WINDOW_LOG2'(1);
                if (win_last) begin
                    pos_cnt     <= '0;
                    neg_cnt     <= '0;
                    speed       <= speed_next;
                    window_done <= 1'b1;
                end else begin
                    pos_cnt <= pos_next;
                    neg_cnt <= neg_next;
                end
            end
        end
    end

    assign speed_o = speed;

    // The NCO sees the pre-update speed, so a window update affects the next tick.
    quad_nco #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_quad_nco (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_en),
        .enable   (enable),
        .step     (speed),
        .encoder_a(encoder_a),
        .encoder_b(encoder_b),
        .position (position_o)
    );

endmodule

// File: doc/bldc_encoder_emulator.md
Name: bldc_encoder_emulator

Overview:
Closed-loop plant model for the BLDC ESC. It consumes the ESC's motor_positive/motor_negative PWM drive and produces quadrature encoder_a/encoder_b, so the speed loop can be exercised on-chip without a motor.
- Drive duty is measured over fixed windows.
- Duty feeds a first-order speed model with gain and friction.
- Speed integrates in a phase NCO whose top two bits are Gray-decoded into A/B.

Parameters:
DATA_WIDTH, 16, width of speed, position and the NCO step
WINDOW_LOG2, 8, log2 of ticks per duty-measurement window
LAG_SHIFT, 3, first-order lag: speed moves (target-speed)>>>LAG_SHIFT per window

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tick_en  input  1  update strobe; state advances only on cycles with tick_en=1
enable  input  1  model enable
motor_positive  input  1  forward drive from ESC
motor_negative  input  1  reverse drive from ESC
gain  input  8  unsigned drive-to-speed gain
friction  input  8  unsigned per-window speed loss toward zero
encoder_a  output  1  quadrature A, registered
encoder_b  output  1  quadrature B, registered
speed_o  output  DATA_WIDTH  signed model speed (NCO step per tick)
position_o  output  DATA_WIDTH  signed quadrant-step count, wraps
window_done  output  1  one-clk pulse when speed is updated
fault  output  1  sticky shoot-through flag

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: all registers zero.
  - encoder_a=0, encoder_b=0, speed_o=0, position_o=0, window_done=0, fault=0.
  - Reset mid-operation aborts the window and clears the phase.
- Gating: with tick_en=0, nothing changes except window_done, which returns to 0 the next cycle.
- Duty measurement, per tick with enable=1:
  - win_ctr (WINDOW_LOG2 bits) increments.
  - pos_cnt increments if positive&!negative.
  - neg_cnt increments if negative&!positive.
  - If both are high: neither counts, and fault is set (sticky until reset).
  - Counters are WINDOW_LOG2+1 bits wide.
- Window end: on the tick where win_ctr = 2^WINDOW_LOG2-1, with that tick's sample included:
  - drive = pos_cnt - neg_cnt (signed, range ±2^WINDOW_LOG2).
  - target = drive * gain.
  - s1 = speed + ((target - speed) >>> LAG_SHIFT).
  - Friction: if s1 > friction then s1 - friction; else if s1 < -friction then s1 + friction; else 0.
  - Compute in DATA_WIDTH+WINDOW_LOG2+10 bits, then saturate symmetrically to ±(2^(DATA_WIDTH-1)-1).
  - speed is registered; counters clear; win_ctr wraps to 0.
  - window_done pulses for exactly one clk, on the following cycle.
- NCO, every tick with enable=1:
  - phase (DATA_WIDTH+2 bits) += sign-extended speed, using the speed value before any same-tick window update.
  - The phase wraps modulo 2^(DATA_WIDTH+2).
  - q = phase top two bits of the new value.
  - {encoder_a,encoder_b} = {q[1], q[1]^q[0]}.
  - Forward sequence is 00→01→11→10, which the ESC decodes as direction 2'b10.
- Gray guarantee: |speed| < 2^(DATA_WIDTH-1) < quadrant size 2^DATA_WIDTH, so at most one quadrant step per tick. A and B never toggle in the same cycle.
- position_o: +1 per forward quadrant step, -1 per reverse step, wraps two's complement.
- enable=0:
  - win_ctr, pos_cnt, neg_cnt and speed are cleared; phase and encoder outputs hold; position holds.
  - On re-enable, the window restarts at 0.
- window_done is not generated while enable=0.

Decomposition:
- Shared package bldc_pkg:
  - localparams for the quadrature Gray table (QUAD_FWD = 00,01,11,10).
  - Saturation limits as functions of DATA_WIDTH.
  - Direction encodings 2'b10 = fwd, 2'b01 = rev, shared with the ESC.
- One natural sub-module: quad_nco. It owns phase accumulation, Gray decode and the position counter, with inputs tick, step, enable.
- Duty measurement and the speed filter remain in the top module.

Test Plan:
1. Reset mid-window after 100 ticks of motor_positive=1 → all outputs 0 immediately. First window_done occurs 256 ticks after reset release.
2. Forward drive: motor_positive=1, gain=1, friction=0, tick_en=1 every clk.
   - Window 1: speed_o=32. Window 2: speed_o=60.
   - Encoder steps 00→01→11→10 (first step at phase 2^16); position_o increments.
3. Reverse drive: motor_negative=1, gain=1 → speed_o=-32 then -60. Encoder 00→10→11→01; position_o decrements to -1, -2, ...
4. Shoot-through: both drives high for 10 ticks in a window, else positive → fault=1 and stays 1; drive=246, so speed_o=30 after window 1.
5. Saturation: gain=255, motor_positive=1 held for 40 windows → speed_o clamps at 32767, never wraps. No cycle has A and B toggling together.
6. Friction/enable: gain=1, friction=40, 50% duty positive → speed_o stays 0. Then enable=0 → speed_o=0, encoder outputs hold their last values.
